// File: rtl/clock_period_meter.sv
// Period and high-time meter for a slow asynchronous input, counted in local clk cycles.
// A synchronized rising edge closes each period and pulses valid with fresh results.
module clock_period_meter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic s1, s2, s3;
  logic [1:0] sync_fill;
  logic rise, fall;

  state_t state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi, hi_n;
  logic [WIDTH-1:0] period_n, high_n;
  logic valid_n, locked_n, overflow_n;

  // sync_fill marks when s2 holds a real sample rather than its reset value, so
  // WAIT_LOW cannot be satisfied by the cleared pipeline while sig_in is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      sync_fill <= '0;
    end else begin
      s1        <= sig_in;
      s2        <= s1;
      s3        <= s2;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_LOW;
      cnt       <= '0;
      hi        <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hi        <= hi_n;
      period    <= period_n;
      high_time <= high_n;
      valid     <= valid_n;
      locked    <= locked_n;
      overflow  <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    hi_n       = hi;
    period_n   = period;
    high_n     = high_time;
    valid_n    = 1'b0;
    locked_n   = locked;
    overflow_n = overflow;
    if (clr) begin
      state_n    = WAIT_LOW;
      locked_n   = 1'b0;
      overflow_n = 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          if (sync_fill[1] && !s2) state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_n   = CNT_ONE;
            hi_n    = '0;
            state_n = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n = cnt;
            high_n   = hi;
            valid_n  = 1'b1;
            locked_n = 1'b1;
            cnt_n    = CNT_ONE;
            hi_n     = '0;
          end else if (cnt == CNT_MAX) begin
            overflow_n = 1'b1;
            locked_n   = 1'b0;
            state_n    = WAIT_LOW;
          end else begin
            cnt_n = cnt + CNT_ONE;
            if (fall) hi_n = cnt;
          end
        end
        default: state_n = WAIT_LOW;
      endcase
    end
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, asynchronous periodic input, such as a divided clock or counter bit, in cycles of the local clock. It is the receiving end of the clock-divider outputs: it checks in hardware what the divider generates. Results go to status registers or display logic, and each fresh measurement is flagged by a one-cycle `valid` strobe.

## Interface
- `WIDTH`, default 16: width of the period/high-time counters and outputs; minimum 2.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- `sig_in`  input  1  signal under measurement; asynchronous to `clk`.
- `clr`  input  1  synchronous clear; re-arms the measurement and clears sticky flags.
- `period`  output  WIDTH  clk cycles between the last two accepted rising edges of `sig_in`.
- `high_time`  output  WIDTH  clk cycles `sig_in` was high within that period.
- `valid`  output  1  one-cycle pulse; `period`/`high_time` updated this cycle.
- `locked`  output  1  at least one full period measured since the last arm; no overflow since.
- `overflow`  output  1  sticky; period exceeded 2^WIDTH-1 cycles.

## Operation
- Synchronizer: `sig_in` passes through flops s1→s2, then an edge register s3. All three reset to 0.
- Edges: rise = s2 & ~s3; fall = ~s2 & s3. Only these drive the logic.
- FSM states: WAIT_LOW, WAIT_RISE, MEASURE. Reset, `clr` and overflow all enter WAIT_LOW.
- WAIT_LOW: ignore edges; go to WAIT_RISE when s2==0. This rejects a fake rise when `sig_in` is high at reset release.
- WAIT_RISE: on rise, set cnt←1 and hi←0, then go to MEASURE.
- MEASURE, every cycle:
  - On rise:
    - period←cnt, high_time←hi, valid←1, locked←1.
    - cnt←1, hi←0; stay in MEASURE.
  - Else, if cnt == 2^WIDTH-1:
    - overflow←1, locked←0; go to WAIT_LOW.
    - No valid strobe; period/high_time keep their old values.
  - Else:
    - cnt←cnt+1.
    - On fall, hi←cnt.
- A rise in the same cycle as cnt == max is a normal capture with period = 2^WIDTH-1.
- No fall between two rises gives high_time = 0.
- `clr` has priority over all edges in the same cycle:
  - go to WAIT_LOW; locked←0, overflow←0, valid←0;
  - period/high_time are kept.
- Reset values: period=0, high_time=0, valid=0, locked=0, overflow=0, cnt=0, hi=0, state=WAIT_LOW.

## Timing
- Measurement is accurate to ±1 clk from synchronizer sampling; a steady input reads exactly.
- Input-edge-to-valid latency is 3 clk edges:
  - edge E0 samples the `sig_in` rise into s1;
  - E1 moves it to s2, so the rise is seen combinationally;
  - at E2, `valid` goes high together with the new `period`/`high_time`.
- `valid` is high for exactly one cycle per accepted rise. It is never high two cycles in a row unless the period is 1, which a synchronized input cannot produce.
- The first `valid` after reset/`clr`/overflow comes on the second accepted rise.
- `sig_in` pulses shorter than one clk period may be missed. No glitch filtering is applied.
- `reset` low mid-measurement clears all outputs at once, independent of `clk`. Operation resumes on the first `clk` edge after release.

## Test plan
- **Divide-by-2 input:** `sig_in` toggles on every clk edge (period 2), from reset.
  - First `valid` on the second accepted rise; period=2, high_time=1, locked=1.
  - `valid` then pulses every 2 cycles.
- **Divide-by-16 input:** `sig_in` is clk/16 with 50% duty.
  - period=16, high_time=8; `valid` every 16 cycles.
  - Change to 25% duty: high_time=4 after the next rise.
- **Limits, WIDTH=4:**
  - Period 15 → period=15, no overflow.
  - Period 16 → overflow=1 and locked=0 when cnt reaches 15; no `valid`; prior period=15 retained.
  - Resume period 8 → `valid` with period=8 after two accepted rises; overflow stays 1 until `clr`.
- **High at reset release:** `sig_in` high when reset is released.
  - No capture until `sig_in` goes low and rises twice.
  - First period correct (e.g. 10 for a clk/10 input); no spurious `valid`.
- **`clr` during measurement:** `clr` asserted in the same cycle as a rise in MEASURE.
  - No `valid`; locked=0, overflow=0; state WAIT_LOW; period/high_time unchanged.
- **Reset mid-period:** `reset` driven low for half a clk cycle mid-period.
  - All outputs 0 immediately, without a clk edge.
  - After release, the first `valid` comes on the second accepted rise.
